swan256_dec_key_schedule: RTL and testbench

- Sequential decryption-side key schedule for SWAN256.
- Takes the 256-bit master key and first runs the encryption key schedule forward ROUNDS steps, one per cycle, to reach the final key state.
- It then steps the schedule backwards one step per handshake, emitting 128-bit round subkeys in reverse order (round ROUNDS down to 1) over a valid/ready interface to the decryption datapath.
- When the last step is undone, it checks that the recovered state equals the master key and reports a mismatch.

---
 rtl/swan256_dec_key_schedule.sv | 121 ++++++++++++
 tb/tb_swan256_dec_key_schedule.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/swan256_dec_key_schedule.sv
// SWAN256 decryption key schedule: runs the forward schedule to the final state,
// then walks it backwards emitting round subkeys ROUNDS..1 and verifies the recovered key.
module swan256_dec_key_schedule #(
  parameter int                   KEY_SIZE   = 256,
  parameter int                   SIDE_SIZE  = 128,
  parameter int                   PD         = 120,
  parameter logic [SIDE_SIZE-1:0] DELTA0     = 128'h9e3779b97f4a7c15f39cc0605cedc834,
  parameter logic [SIDE_SIZE-1:0] DELTA_INIT = 128'h0,
  parameter int                   ROUNDS     = 64,
  parameter int                   CW         = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [KEY_SIZE-1:0]  key_in,
  output logic                 busy,
  output logic                 sk_valid,
  input  logic                 sk_ready,
  output logic [SIDE_SIZE-1:0] sk,
  output logic [CW-1:0]        sk_round,
  output logic                 done,
  output logic                 key_err
);

  typedef enum logic [1:0] {IDLE, FWD, EMIT, CHECK} state_t;

  localparam logic [CW-1:0] LAST = CW'(ROUNDS);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t                 state_q, state_d;
  logic [KEY_SIZE-1:0]    key_q, key_d, master_q, master_d;
  logic [SIDE_SIZE-1:0]   delta_q, delta_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   err_q, err_d;

  logic [SIDE_SIZE-1:0]   delta_fwd, delta_inv, side_inv;
  logic [KEY_SIZE-1:0]    key_rot, key_fwd, key_inv;

  // Numeric rotations; bit 0 of the spec's big-endian view is our MSB.
  function automatic logic [KEY_SIZE-1:0] rotr(input logic [KEY_SIZE-1:0] k);
    return {k[PD-1:0], k[KEY_SIZE-1:PD]};
  endfunction

  function automatic logic [KEY_SIZE-1:0] rotl(input logic [KEY_SIZE-1:0] k);
    return {k[KEY_SIZE-PD-1:0], k[KEY_SIZE-1:KEY_SIZE-PD]};
  endfunction

  assign delta_fwd = delta_q + DELTA0;
  assign key_rot   = rotr(key_q);
  assign key_fwd   = {key_rot[KEY_SIZE-1:SIDE_SIZE], key_rot[SIDE_SIZE-1:0] + delta_fwd};

  assign side_inv  = key_q[SIDE_SIZE-1:0] - delta_q;
  assign key_inv   = rotl({key_q[KEY_SIZE-1:SIDE_SIZE], side_inv});
  assign delta_inv = delta_q - DELTA0;

  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    master_d = master_q;
    delta_d  = delta_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          key_d    = key_in;
          master_d = key_in;
          delta_d  = DELTA_INIT;
          cnt_d    = '0;
          err_d    = 1'b0;
          state_d  = FWD;
        end
      end
      FWD: begin
        key_d   = key_fwd;
        delta_d = delta_fwd;
        cnt_d   = cnt_q + ONE;
        if (cnt_q + ONE == LAST) state_d = EMIT;
      end
      EMIT: begin
        if (sk_ready) begin
          key_d   = key_inv;
          delta_d = delta_inv;
          cnt_d   = cnt_q - ONE;
          if (cnt_q == ONE) state_d = CHECK;
        end
      end
      CHECK: begin
        err_d   = (key_q != master_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      key_q    <= '0;
      master_q <= '0;
      delta_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      master_q <= master_d;
      delta_q  <= delta_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign sk_valid = (state_q == EMIT);
  assign done     = (state_q == CHECK);
  assign sk       = key_q[SIDE_SIZE-1:0];
  assign sk_round = cnt_q;
  assign key_err  = err_q;

endmodule

// File: tb/tb_swan256_dec_key_schedule.sv
// Bench for swan256_dec_key_schedule: three instances (ROUNDS=1, 2, 64) checked against
// a forward arithmetic model whose subkey list is consumed in reverse.
module tb_swan256_dec_key_schedule;

  localparam logic [127:0] DELTA0 = 128'h9e3779b97f4a7c15f39cc0605cedc834;
  localparam logic [127:0] SK_R2  = 128'h3c6ef372fe94f82be73980c0b9db9106;
  localparam int           PD     = 120;

  logic               clk;
  logic               rst_n;
  logic               start    [3];
  logic [255:0]       key_in   [3];
  logic               sk_ready [3];
  logic               busy     [3];
  logic               sk_valid [3];
  logic [127:0]       sk       [3];
  logic [6:0]         sk_round [3];
  logic               done     [3];
  logic               key_err  [3];

  int passed = 0;
  int total  = 0;
  logic [127:0] exp_sk [1:64];
  logic [127:0] got_sk [1:64];

  swan256_dec_key_schedule #(.ROUNDS(1), .CW(7)) u_r1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .key_in(key_in[0]), .busy(busy[0]),
    .sk_valid(sk_valid[0]), .sk_ready(sk_ready[0]), .sk(sk[0]), .sk_round(sk_round[0]),
    .done(done[0]), .key_err(key_err[0]));

  swan256_dec_key_schedule #(.ROUNDS(2), .CW(7)) u_r2 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .key_in(key_in[1]), .busy(busy[1]),
    .sk_valid(sk_valid[1]), .sk_ready(sk_ready[1]), .sk(sk[1]), .sk_round(sk_round[1]),
    .done(done[1]), .key_err(key_err[1]));

  swan256_dec_key_schedule u_def (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .key_in(key_in[2]), .busy(busy[2]),
    .sk_valid(sk_valid[2]), .sk_ready(sk_ready[2]), .sk(sk[2]), .sk_round(sk_round[2]),
    .done(done[2]), .key_err(key_err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           u;
    logic [255:0] key;
    int           rounds;
    int           rnd;
    logic [127:0] exp;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic chk_zero(input int u, input string tag);
    chk({tag, "_busy"},     128'(busy[u]),     128'(0));
    chk({tag, "_sk_valid"}, 128'(sk_valid[u]), 128'(0));
    chk({tag, "_done"},     128'(done[u]),     128'(0));
    chk({tag, "_key_err"},  128'(key_err[u]),  128'(0));
    chk({tag, "_sk"},       sk[u],             128'(0));
    chk({tag, "_sk_round"}, 128'(sk_round[u]), 128'(0));
  endtask

  // Full operation on unit u; ends at the negedge inside the completion cycle.
  task automatic run_op(input int u, input logic [255:0] key, input int rounds,
                        input int ready_pct, input bit poke, input int abort_after);
    int lat, r, guard, acc, dones;
    bit ready;
    logic [255:0] k;
    logic [127:0] d;
    k = key;
    d = 128'h0;
    for (int i = 1; i <= rounds; i++) begin
      k = (k >> PD) | (k << (256 - PD));
      d = d + DELTA0;
      k[127:0] = k[127:0] + d;
      exp_sk[i] = k[127:0];
    end
    @(negedge clk);
    chk("idle_busy",    128'(busy[u]),    128'(0));
    chk("idle_done",    128'(done[u]),    128'(0));
    chk("idle_key_err", 128'(key_err[u]), 128'(0));
    start[u]  = 1'b1;
    key_in[u] = key;
    @(negedge clk);
    start[u] = 1'b0;
    dones = 0;
    lat = 0;
    while (!sk_valid[u] && lat < rounds + 5) begin
      dones += int'(done[u]);
      if (poke) start[u] = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    start[u] = 1'b0;
    chk("latency", 128'(lat), 128'(rounds));
    chk("busy_at_valid", 128'(busy[u]), 128'(1));
    r = rounds;
    acc = 0;
    guard = 0;
    while (r >= 1 && guard < 20 * rounds + 20) begin
      guard++;
      dones += int'(done[u]);
      if (!sk_valid[u]) begin
        chk("emit_valid", 128'(sk_valid[u]), 128'(1));
        break;
      end
      chk("sk", sk[u], exp_sk[r]);
      chk("sk_round", 128'(sk_round[u]), 128'(r));
      if (abort_after > 0 && acc == abort_after) begin
        rst_n = 1'b0;
        sk_ready[u] = 1'b0;
        @(negedge clk);
        chk_zero(u, "abort");
        dones += int'(done[u]);
        chk("abort_no_done", 128'(dones), 128'(0));
        rst_n = 1'b1;
        return;
      end
      ready = (int'($urandom_range(0, 99)) < ready_pct);
      sk_ready[u] = ready;
      if (poke) start[u] = 1'($urandom_range(0, 1));
      if (ready) begin
        got_sk[r] = sk[u];
        r--;
        acc++;
      end
      @(negedge clk);
    end
    sk_ready[u] = 1'b0;
    start[u] = 1'b0;
    chk("emitted_count", 128'(acc), 128'(rounds));
    chk("check_done", 128'(done[u]), 128'(1));
    chk("check_valid", 128'(sk_valid[u]), 128'(0));
    dones += int'(done[u]);
    chk("done_pulses", 128'(dones), 128'(1));
  endtask

  initial begin
    logic [255:0] rk;
    tbl[0] = '{u: 0, key: 256'h0, rounds: 1,  rnd: 1, exp: DELTA0};
    tbl[1] = '{u: 1, key: 256'h0, rounds: 2,  rnd: 2, exp: SK_R2};
    tbl[2] = '{u: 1, key: 256'h0, rounds: 2,  rnd: 1, exp: DELTA0};
    tbl[3] = '{u: 2, key: 256'h0, rounds: 64, rnd: 2, exp: SK_R2};
    tbl[4] = '{u: 2, key: 256'h0, rounds: 64, rnd: 1, exp: DELTA0};

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      key_in[i] = '0;
      sk_ready[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) chk_zero(i, "reset");
    rst_n = 1'b1;

    // Known-answer vectors for key 0, streaming with sk_ready held high.
    for (int i = 0; i < 5; i++) begin
      run_op(tbl[i].u, tbl[i].key, tbl[i].rounds, 100, 1'b0, 0);
      chk("table_sk", got_sk[tbl[i].rnd], tbl[i].exp);
    end

    // Random keys, random stalls, stray start pulses; each op back-to-back with the previous.
    for (int t = 0; t < 3; t++) begin
      rk = '0;
      for (int w = 0; w < 8; w++) rk = {rk[223:0], 32'($urandom())};
      run_op(2, rk, 64, 50, 1'b1, 0);
    end

    // Reset after three accepted subkeys, then a full run from round 64.
    rk = '0;
    for (int w = 0; w < 8; w++) rk = {rk[223:0], 32'($urandom())};
    run_op(2, rk, 64, 100, 1'b0, 3);
    run_op(2, rk, 64, 70, 1'b0, 0);

    @(negedge clk);
    chk("final_key_err", 128'(key_err[2]), 128'(0));
    chk("final_busy", 128'(busy[2]), 128'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
